// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 7-segment scan path and its downstream decoder.
// Used by both builds; the SEG7_LEADING_ZERO_BLANK_EN option lives in seg7_digit_scan.
package seg7_pkg;

    localparam int   DIGIT_W    = 4;
    localparam int   MAX_DIGITS = 8;
    localparam logic AN_OFF     = 1'b1;

    typedef logic [DIGIT_W-1:0] digit_t;

    // Active-low one-hot select; positions at or beyond n stay off.
    function automatic logic [MAX_DIGITS-1:0] onehot_low(input int idx, input int n);
        logic [MAX_DIGITS-1:0] r;
        r = {MAX_DIGITS{AN_OFF}};
        for (int k = 0; k < MAX_DIGITS; k++) begin
            if (k == idx && k < n) begin
                r[k] = ~AN_OFF;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_tick_div.sv
// Refresh divider: counts clock cycles within one digit slot and flags the slot's last cycle.
// Identical in all builds, including when SEG7_LEADING_ZERO_BLANK_EN is defined.
module seg7_tick_div #(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = $clog2(REFRESH_DIV)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] cnt_o,
    output logic             term_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             term;

    assign term = (cnt_q == CNT_W'(REFRESH_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (term) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign term_o = term;

endmodule

// File: rtl/seg7_digit_scan.sv
// Time-multiplexed scanner for an N-digit common-anode display with per-frame snapshots.
// Define SEG7_LEADING_ZERO_BLANK_EN to suppress leading zero digits (digit 0 always shown).
module seg7_digit_scan
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_DIGITS*4-1:0] value_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic                    blank_i,
    output logic [3:0]              digit_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    dp_o,
    output logic                    tick_o,
    output logic                    frame_o
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(REFRESH_DIV);

    logic [CNT_W-1:0]              cnt;
    logic                          term;
    logic [IDX_W-1:0]              idx_q, idx_d;
    digit_t [NUM_DIGITS-1:0]       snap_q, snap_d;
    logic [NUM_DIGITS-1:0]         dps_q, dps_d;
    logic                          blank_q;
    logic                          load_pend_q, load_pend_d;
    logic                          last_idx;
    logic                          frame;
    logic [NUM_DIGITS-1:0]         suppress;
    logic                          in_guard;
    digit_t                        sel_digit;
    logic                          sel_dp;
    logic                          sel_sup;
    logic                          an_on;

    seg7_tick_div #(
        .REFRESH_DIV (REFRESH_DIV),
        .CNT_W       (CNT_W)
    ) u_tick_div (
        .clk    (clk),
        .rst    (rst),
        .cnt_o  (cnt),
        .term_o (term)
    );

    assign last_idx = (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign frame    = term & last_idx;

    // Snapshot refreshes only at frame boundaries so a frame never mixes old and new digits.
    always_comb begin
        idx_d       = idx_q;
        snap_d      = snap_q;
        dps_d       = dps_q;
        load_pend_d = load_pend_q;
        if (term) begin
            idx_d = last_idx ? '0 : idx_q + IDX_W'(1);
        end
        if (frame || load_pend_q) begin
            snap_d      = value_i;
            dps_d       = dp_i;
            load_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q       <= '0;
            snap_q      <= '0;
            dps_q       <= '0;
            blank_q     <= 1'b1;
            load_pend_q <= 1'b1;
        end else begin
            idx_q       <= idx_d;
            snap_q      <= snap_d;
            dps_q       <= dps_d;
            blank_q     <= blank_i;
            load_pend_q <= load_pend_d;
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // A digit is dark when it and every more-significant digit are zero.
    always_comb begin
        logic zero_run;
        suppress = '0;
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            zero_run    = zero_run & (snap_q[k] == '0);
            suppress[k] = zero_run;
        end
    end
`else
    assign suppress = '0;
`endif

    generate
        if (GUARD == 0) begin : g_no_guard
            assign in_guard = 1'b0;
        end else begin : g_guard
            assign in_guard = (cnt < CNT_W'(GUARD));
        end
    endgenerate

    always_comb begin
        sel_digit = '0;
        sel_dp    = 1'b0;
        sel_sup   = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                sel_digit = snap_q[k];
                sel_dp    = dps_q[k];
                sel_sup   = suppress[k];
            end
        end
    end

    assign an_on   = ~blank_q & ~in_guard & ~sel_sup;
    assign an_o    = an_on ? NUM_DIGITS'(onehot_low(int'(idx_q), NUM_DIGITS))
                           : {NUM_DIGITS{AN_OFF}};
    assign dp_o    = an_on ? ~sel_dp : AN_OFF;
    assign digit_o = sel_digit;
    assign tick_o  = term;
    assign frame_o = frame;

endmodule

// File: tb/tb_seg7_digit_scan.sv
// Bench for seg7_digit_scan (NUM_DIGITS=4, REFRESH_DIV=4, GUARD=1) against a cycle-count model.
// Expectations follow SEG7_LEADING_ZERO_BLANK_EN when the bench is built with it.
module tb_seg7_digit_scan;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int GUARD = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] value_i;
    logic [3:0]  dp_i;
    logic        blank_i;
    logic [3:0]  digit_o;
    logic [3:0]  an_o;
    logic        dp_o;
    logic        tick_o;
    logic        frame_o;

    int total = 0;
    int bad   = 0;

    int          t;
    logic [15:0] mSnap;
    logic [3:0]  mDps;
    logic        mBlank;
    logic        mPend;

    seg7_digit_scan #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (DIV),
        .GUARD       (GUARD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .value_i (value_i),
        .dp_i    (dp_i),
        .blank_i (blank_i),
        .digit_o (digit_o),
        .an_o    (an_o),
        .dp_o    (dp_o),
        .tick_o  (tick_o),
        .frame_o (frame_o)
    );

    always #5 clk = ~clk;

    // The model only counts edges since reset; slot position and digit index follow from t.
    task automatic modelReset();
        t      = 0;
        mSnap  = '0;
        mDps   = '0;
        mBlank = 1'b1;
        mPend  = 1'b1;
    endtask

    task automatic tick_model();
        @(posedge clk);
        if (!rst) begin
            if (mPend || ((t % DIV) == DIV - 1 && ((t / DIV) % N) == N - 1)) begin
                mSnap = value_i;
                mDps  = dp_i;
                mPend = 1'b0;
            end
            mBlank = blank_i;
            t++;
        end
        #1;
    endtask

    function automatic logic [10:0] expected();
        int         cnt;
        int         idx;
        logic [3:0] dig;
        logic       sup;
        logic       on;
        logic [3:0] an;
        logic       dp;
        logic       tk;
        logic       fr;
        cnt = t % DIV;
        idx = (t / DIV) % N;
        dig = 4'((mSnap >> (4 * idx)) & 16'hF);
        sup = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (idx > 0 && (mSnap >> (4 * idx)) == 16'h0) sup = 1'b1;
`endif
        on = !mBlank && cnt >= GUARD && !sup;
        an = on ? ~(4'b0001 << idx) : 4'hF;
        dp = on ? ~mDps[idx] : 1'b1;
        tk = (cnt == DIV - 1);
        fr = tk && (idx == N - 1);
        return {dig, an, dp, tk, fr};
    endfunction

    task automatic test_reset();
        value_i = 16'h1234;
        dp_i    = 4'b0000;
        blank_i = 1'b0;
        modelReset();
        #2 rst = 1'b1;
        #1;
        total++;
        if ({digit_o, an_o, dp_o, tick_o, frame_o} !== expected()) begin
            bad++;
            $display("FAIL reset_async got=%h want=%h", {digit_o, an_o, dp_o, tick_o, frame_o}, expected());
        end
        tick_model();
        total++;
        if ({digit_o, an_o, dp_o, tick_o, frame_o} !== expected()) begin
            bad++;
            $display("FAIL reset_held got=%h want=%h", {digit_o, an_o, dp_o, tick_o, frame_o}, expected());
        end
        rst = 1'b0;
    endtask

    task automatic test_scan();
        int ticks = 0;
        int frames = 0;
        for (int i = 0; i < 32; i++) begin
            tick_model();
            ticks  += int'(tick_o);
            frames += int'(frame_o);
            total++;
            if ({digit_o, an_o, dp_o, tick_o, frame_o} !== expected()) begin
                bad++;
                $display("FAIL scan t=%0d got=%h want=%h", t, {digit_o, an_o, dp_o, tick_o, frame_o}, expected());
            end
        end
        total++;
        if (ticks != 8 || frames != 2) begin
            bad++;
            $display("FAIL scan_pulse_count got=%0d/%0d want=8/2", ticks, frames);
        end
    endtask

    task automatic test_snapshot();
        int guardCnt = 0;
        while (((t / DIV) % N) != 1 && guardCnt < 64) begin
            tick_model();
            guardCnt++;
        end
        total++;
        if (guardCnt >= 64) begin
            bad++;
            $display("FAIL snapshot_wait got=timeout want=idx1");
        end
        value_i = 16'hABCD;
        for (int i = 0; i < 28; i++) begin
            tick_model();
            total++;
            if ({digit_o, an_o, dp_o, tick_o, frame_o} !== expected()) begin
                bad++;
                $display("FAIL snapshot t=%0d got=%h want=%h", t, {digit_o, an_o, dp_o, tick_o, frame_o}, expected());
            end
        end
    endtask

    task automatic test_dp();
        dp_i = 4'b0100;
        for (int i = 0; i < 36; i++) begin
            tick_model();
            total++;
            if ({digit_o, an_o, dp_o, tick_o, frame_o} !== expected()) begin
                bad++;
                $display("FAIL dp t=%0d got=%h want=%h", t, {digit_o, an_o, dp_o, tick_o, frame_o}, expected());
            end
        end
        dp_i = 4'b0000;
    endtask

    task automatic test_blank();
        int guardCnt = 0;
        while ((t % DIV) != 1 && guardCnt < 16) begin
            tick_model();
            guardCnt++;
        end
        total++;
        if (guardCnt >= 16) begin
            bad++;
            $display("FAIL blank_wait got=timeout want=cnt1");
        end
        blank_i = 1'b1;
        tick_model();
        blank_i = 1'b0;
        total++;
        if (an_o !== 4'hF || {digit_o, an_o, dp_o, tick_o, frame_o} !== expected()) begin
            bad++;
            $display("FAIL blank_on t=%0d got=%h want=%h", t, {digit_o, an_o, dp_o, tick_o, frame_o}, expected());
        end
        for (int i = 0; i < 6; i++) begin
            tick_model();
            total++;
            if ({digit_o, an_o, dp_o, tick_o, frame_o} !== expected()) begin
                bad++;
                $display("FAIL blank_after t=%0d got=%h want=%h", t, {digit_o, an_o, dp_o, tick_o, frame_o}, expected());
            end
        end
    endtask

    task automatic test_async_reset();
        int guardCnt = 0;
        while (!((t % DIV) == 2 && ((t / DIV) % N) == 2) && guardCnt < 64) begin
            tick_model();
            guardCnt++;
        end
        total++;
        if (guardCnt >= 64) begin
            bad++;
            $display("FAIL async_wait got=timeout want=idx2cnt2");
        end
        rst = 1'b1;
        modelReset();
        #1;
        total++;
        if (an_o !== 4'hF || dp_o !== 1'b1 || {digit_o, an_o, dp_o, tick_o, frame_o} !== expected()) begin
            bad++;
            $display("FAIL async_reset got=%h want=%h", {digit_o, an_o, dp_o, tick_o, frame_o}, expected());
        end
        tick_model();
        tick_model();
        rst     = 1'b0;
        value_i = 16'h5A0F;
        for (int i = 0; i < 20; i++) begin
            tick_model();
            total++;
            if ({digit_o, an_o, dp_o, tick_o, frame_o} !== expected()) begin
                bad++;
                $display("FAIL after_reset t=%0d got=%h want=%h", t, {digit_o, an_o, dp_o, tick_o, frame_o}, expected());
            end
        end
    endtask

    task automatic test_zero_digits();
        value_i = 16'h0042;
        for (int i = 0; i < 36; i++) begin
            tick_model();
            total++;
            if ({digit_o, an_o, dp_o, tick_o, frame_o} !== expected()) begin
                bad++;
                $display("FAIL zeros42 t=%0d got=%h want=%h", t, {digit_o, an_o, dp_o, tick_o, frame_o}, expected());
            end
        end
        value_i = 16'h0000;
        for (int i = 0; i < 36; i++) begin
            tick_model();
            total++;
            if ({digit_o, an_o, dp_o, tick_o, frame_o} !== expected()) begin
                bad++;
                $display("FAIL zeros00 t=%0d got=%h want=%h", t, {digit_o, an_o, dp_o, tick_o, frame_o}, expected());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            value_i = 16'($urandom);
            if ($urandom_range(3) == 0) value_i[15:8] = 8'h00;
            dp_i    = 4'($urandom);
            blank_i = ($urandom_range(7) == 0);
            tick_model();
            total++;
            if ({digit_o, an_o, dp_o, tick_o, frame_o} !== expected()) begin
                bad++;
                $display("FAIL random t=%0d got=%h want=%h", t, {digit_o, an_o, dp_o, tick_o, frame_o}, expected());
            end
        end
        blank_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_snapshot();
        test_dp();
        test_blank();
        test_async_reset();
        test_zero_digits();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
